// File: rtl/counter_pkg.sv
// Shared definitions for the counter operation scheduler: operation codes
// issued to the counter/output stage and the scheduler FSM encoding.
package counter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_INC  = 3'b001;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b010;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b011;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b100;
    localparam logic [OP_W-1:0] OP_REF  = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/counter_op_scheduler_if.sv
// Request pulses in, one operation at a time out over valid/ready.
// master: the scheduler; slave: the trigger sources and datapath side.
interface counter_op_scheduler_if;
    import counter_pkg::*;

    logic            inc_req;
    logic            dec_req;
    logic            load_req;
    logic            clr_req;
    logic            ref_req;
    logic            op_ready;
    logic            op_valid;
    logic [OP_W-1:0] op_code;
    logic            busy;
    logic            ovf;

    modport master (
        input  inc_req, dec_req, load_req, clr_req, ref_req, op_ready,
        output op_valid, op_code, busy, ovf
    );

    modport slave (
        output inc_req, dec_req, load_req, clr_req, ref_req, op_ready,
        input  op_valid, op_code, busy, ovf
    );

endinterface

// File: rtl/pend_counter.sv
// Saturating pending-request counter. A consume (dec) or flush is applied
// first, then an incoming pulse is counted on top of the result, so a pulse
// arriving together with a consume or flush is never lost. A pulse that
// would exceed the maximum is dropped and reported on ovf_pulse.
module pend_counter #(
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              flush,
    output logic [PEND_W-1:0] cnt,
    output logic              ovf_pulse
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic [PEND_W-1:0] base;

    // Next count: flush/consume first, then add the new pulse or flag overflow.
    always_comb begin
        base      = cnt_q;
        cnt_d     = cnt_q;
        ovf_pulse = 1'b0;
        if (flush) begin
            base = '0;
        end else if (dec && (cnt_q != '0)) begin
            base = cnt_q - PEND_W'(1);
        end
        cnt_d = base;
        if (inc) begin
            if (base == CNT_MAX) begin
                ovf_pulse = 1'b1;
            end else begin
                cnt_d = base + PEND_W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/counter_op_scheduler.sv
// Collects trigger pulses as pending requests, arbitrates them with fixed
// priority CLR > LOAD > INC/DEC (round-robin) > REF, and issues one operation
// at a time over valid/ready. A granted operation is consumed only when the
// datapath accepts it. REF grants are rate-limited by a holdoff counter.
module counter_op_scheduler #(
    parameter int PEND_W  = 4,
    parameter int REF_GAP = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    counter_op_scheduler_if.master bus
);
    import counter_pkg::*;

    localparam int HO_W = $clog2(REF_GAP + 1);

    state_e            state_q, state_d;
    logic              op_valid_q, op_valid_d;
    logic [OP_W-1:0]   op_code_q, op_code_d;
    logic              load_p_q, load_p_d;
    logic              clr_p_q, clr_p_d;
    logic              ref_p_q, ref_p_d;
    logic              rr_q, rr_d;
    logic              ovf_q, ovf_d;
    logic [HO_W-1:0]   holdoff_q, holdoff_d;

    logic [PEND_W-1:0] inc_cnt, dec_cnt;
    logic              inc_ovf, dec_ovf;
    logic              ref_elig;
    logic [OP_W-1:0]   win;
    logic              issue, accept;
    logic              cons_inc, cons_dec, cons_load, cons_clr, cons_ref;
    logic              clr_grant, ref_grant, incdec_grant;

    // Pending INC and DEC counts; a CLR grant flushes both.
    pend_counter #(.PEND_W(PEND_W)) u_inc_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (bus.inc_req),
        .dec       (cons_inc),
        .flush     (clr_grant),
        .cnt       (inc_cnt),
        .ovf_pulse (inc_ovf)
    );

    pend_counter #(.PEND_W(PEND_W)) u_dec_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (bus.dec_req),
        .dec       (cons_dec),
        .flush     (clr_grant),
        .cnt       (dec_cnt),
        .ovf_pulse (dec_ovf)
    );

    // Fixed-priority arbiter over registered pending state.
    always_comb begin
        ref_elig = ref_p_q && (holdoff_q == '0);
        win      = OP_NOP;
        if (clr_p_q) begin
            win = OP_CLR;
        end else if (load_p_q) begin
            win = OP_LOAD;
        end else if ((inc_cnt != '0) && (dec_cnt != '0)) begin
            win = rr_q ? OP_DEC : OP_INC;
        end else if (inc_cnt != '0) begin
            win = OP_INC;
        end else if (dec_cnt != '0) begin
            win = OP_DEC;
        end else if (ref_elig) begin
            win = OP_REF;
        end
    end

    // FSM next state and handshake outputs: register the winner in IDLE,
    // hold it in ISSUE until accepted.
    always_comb begin
        state_d    = state_q;
        op_valid_d = op_valid_q;
        op_code_d  = op_code_q;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win != OP_NOP) begin
                    op_code_d  = win;
                    op_valid_d = 1'b1;
                    state_d    = ST_ISSUE;
                    issue      = 1'b1;
                end else begin
                    op_code_d  = OP_NOP;
                    op_valid_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (bus.op_ready) begin
                    accept     = 1'b1;
                    op_valid_d = 1'b0;
                    op_code_d  = OP_NOP;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                op_valid_d = 1'b0;
                op_code_d  = OP_NOP;
            end
        endcase
    end

    // Grant side effects and consumption of the accepted source. Flags merge
    // repeated pulses; a pulse on the consume edge keeps the flag set.
    always_comb begin
        cons_inc     = accept && (op_code_q == OP_INC);
        cons_dec     = accept && (op_code_q == OP_DEC);
        cons_load    = accept && (op_code_q == OP_LOAD);
        cons_clr     = accept && (op_code_q == OP_CLR);
        cons_ref     = accept && (op_code_q == OP_REF);
        clr_grant    = issue && (win == OP_CLR);
        ref_grant    = issue && (win == OP_REF);
        incdec_grant = issue && ((win == OP_INC) || (win == OP_DEC));

        load_p_d = (load_p_q && !cons_load) || bus.load_req;
        clr_p_d  = (clr_p_q  && !cons_clr)  || bus.clr_req;
        ref_p_d  = (ref_p_q  && !cons_ref)  || bus.ref_req;
        rr_d     = rr_q ^ incdec_grant;

        if (clr_grant) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q || inc_ovf || dec_ovf;
        end

        if (ref_grant) begin
            holdoff_d = HO_W'(REF_GAP);
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HO_W'(1);
        end else begin
            holdoff_d = holdoff_q;
        end
    end

    // State, handshake and pending-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_valid_q <= 1'b0;
            op_code_q  <= OP_NOP;
            load_p_q   <= 1'b0;
            clr_p_q    <= 1'b0;
            ref_p_q    <= 1'b0;
            rr_q       <= 1'b0;
            ovf_q      <= 1'b0;
            holdoff_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_valid_q <= op_valid_d;
            op_code_q  <= op_code_d;
            load_p_q   <= load_p_d;
            clr_p_q    <= clr_p_d;
            ref_p_q    <= ref_p_d;
            rr_q       <= rr_d;
            ovf_q      <= ovf_d;
            holdoff_q  <= holdoff_d;
        end
    end

    assign bus.op_valid = op_valid_q;
    assign bus.op_code  = op_code_q;
    assign bus.ovf      = ovf_q;
    assign bus.busy     = op_valid_q | clr_p_q | load_p_q | ref_p_q
                        | (inc_cnt != '0) | (dec_cnt != '0);

endmodule

// File: tb/tb_counter_op_scheduler.sv
// Scoreboard bench for counter_op_scheduler: stimulus pushes the expected
// grant (op_code and, where fixed, the cycle of acceptance); a monitor pops
// and compares on every accepted handshake.
module tb_counter_op_scheduler;
    import counter_pkg::*;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];
    exp_t mon_e;

    counter_op_scheduler_if bus();

    counter_op_scheduler #(.PEND_W(4), .REF_GAP(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(logic [2:0] code, int c);
        exp_t e;
        e.code = code;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(string name, int max);
        int i = 0;
        while ((bus.busy || exp_q.size() != 0) && i < max) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (bus.busy || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: busy=%0b outstanding=%0d after %0d cycles, required idle",
                     name, bus.busy, exp_q.size(), max);
        end
    endtask

    // Monitor: every accepted handshake must match the next expected grant.
    always @(negedge clk) begin
        if (reset && bus.op_valid && bus.op_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got op_code %0d at cycle %0d, required none",
                         bus.op_code, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("grant_code", int'(bus.op_code), int'(mon_e.code));
                if (mon_e.cyc >= 0) check("grant_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int r;
        int s;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.inc_req  = 1'b0;
        bus.dec_req  = 1'b0;
        bus.load_req = 1'b0;
        bus.clr_req  = 1'b0;
        bus.ref_req  = 1'b0;
        bus.op_ready = 1'b1;

        // Reset state
        repeat (2) step();
        check("rst_op_valid", int'(bus.op_valid), 0);
        check("rst_op_code",  int'(bus.op_code),  int'(OP_NOP));
        check("rst_busy",     int'(bus.busy),     0);
        check("rst_ovf",      int'(bus.ovf),      0);
        reset = 1'b1;

        // 1: single INC, valid two cycles after the pulse, gone the cycle after
        while (cyc < 5) step();
        p = cyc;
        push(OP_INC, p + 2);
        bus.inc_req = 1'b1;
        step();
        bus.inc_req = 1'b0;
        wait_cyc(p + 3);
        check("t1_valid_after", int'(bus.op_valid), 0);
        check("t1_busy_after",  int'(bus.busy),     0);

        // 2: saturation at 15, sticky ovf, exactly 15 grants, CLR clears ovf
        bus.op_ready = 1'b0;
        step();
        bus.inc_req = 1'b1;
        repeat (20) step();
        bus.inc_req = 1'b0;
        step();
        check("t2_ovf_set",   int'(bus.ovf),      1);
        check("t2_busy",      int'(bus.busy),     1);
        check("t2_held_code", int'(bus.op_code),  int'(OP_INC));
        r = cyc;
        for (int i = 0; i < 15; i++) push(OP_INC, r + 2 * i);
        bus.op_ready = 1'b1;
        drain("t2_inc", 60);
        check("t2_ovf_sticky", int'(bus.ovf), 1);
        step();
        p = cyc;
        push(OP_CLR, p + 2);
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        drain("t2_clr", 10);
        check("t2_ovf_cleared", int'(bus.ovf), 0);

        // 3: priority order; the INC pulse lands on the CLR grant edge and survives the flush
        step();
        p = cyc;
        push(OP_CLR,  p + 2);
        push(OP_LOAD, p + 4);
        push(OP_INC,  p + 6);
        push(OP_REF,  p + 8);
        bus.clr_req  = 1'b1;
        bus.load_req = 1'b1;
        bus.ref_req  = 1'b1;
        step();
        bus.clr_req  = 1'b0;
        bus.load_req = 1'b0;
        bus.ref_req  = 1'b0;
        bus.inc_req  = 1'b1;
        step();
        bus.inc_req  = 1'b0;
        drain("t3", 20);
        check("t3_ovf", int'(bus.ovf), 0);

        // 6: reset while an op is held unaccepted
        bus.op_ready = 1'b0;
        step();
        p = cyc;
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        bus.inc_req  = 1'b1;
        step();
        bus.inc_req  = 1'b0;
        wait_cyc(p + 3);
        check("t6_pre_valid", int'(bus.op_valid), 1);
        check("t6_pre_code",  int'(bus.op_code),  int'(OP_LOAD));
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", int'(bus.op_valid), 0);
        check("t6_rst_code",  int'(bus.op_code),  int'(OP_NOP));
        check("t6_rst_busy",  int'(bus.busy),     0);
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("t6_post_valid", int'(bus.op_valid), 0);
        check("t6_post_code",  int'(bus.op_code),  int'(OP_NOP));
        check("t6_post_busy",  int'(bus.busy),     0);
        check("t6_post_ovf",   int'(bus.ovf),      0);

        // 4: INC/DEC round-robin from rr=0, grants every other cycle
        step();
        bus.inc_req = 1'b1;
        bus.dec_req = 1'b1;
        repeat (3) step();
        bus.inc_req = 1'b0;
        bus.dec_req = 1'b0;
        repeat (2) step();
        r = cyc;
        for (int i = 0; i < 6; i++) push((i % 2 == 0) ? OP_INC : OP_DEC, r + 2 * i);
        bus.op_ready = 1'b1;
        drain("t4", 30);

        // 5: REF every 4 cycles is held off 17 cycles; INCs pass during holdoff
        step();
        s = cyc;
        push(OP_REF, s + 2);
        push(OP_INC, s + 8);
        push(OP_INC, s + 12);
        push(OP_REF, s + 19);
        push(OP_REF, s + 36);
        push(OP_REF, s + 53);
        for (int k = 0; k <= 40; k++) begin
            bus.ref_req = (k % 4 == 0);
            bus.inc_req = (k == 6) || (k == 10);
            step();
        end
        bus.ref_req = 1'b0;
        bus.inc_req = 1'b0;
        drain("t5", 100);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
